// File: rtl/ifu_fetch.sv
// ifu_fetch: owns the PC, fetches from instruction memory into IF/ID and
// applies decode-stage redirects with MIPS delay-slot semantics.
module ifu_fetch #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter logic [31:0] PC_LO    = 32'h0000_3000,
   parameter logic [31:0] PC_HI    = 32'h0000_4FFC
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic [1:0]  NPCSel,
   input  logic        BranchTaken,
   input  logic [15:0] Imm16,
   input  logic [25:0] Index26,
   input  logic [31:0] RegRs,
   output logic [10:0] ImAddr,
   input  logic [31:0] ImData,
   output logic [31:0] PC_F,
   output logic [31:0] IR_D,
   output logic [31:0] PC_D,
   output logic [31:0] PC8_D,
   output logic        FetchErr_D,
   output logic [31:0] FetchCnt
);
   logic        legal;
   logic [31:0] seq_pc, br_pc, npc;
   always_comb begin
      legal  = (PC_F >= PC_LO) && (PC_F <= PC_HI) && (PC_F[1:0] == 2'b00);
      seq_pc = PC_F + 32'd4;
      br_pc  = PC_D + 32'd4 + {{14{Imm16[15]}}, Imm16, 2'b00};
      // Branch/jump targets are relative to the instruction in decode (PC_D), not PC_F.
      npc    = NPCSel == 2'b11 ? RegRs :
               NPCSel == 2'b10 ? {PC_D[31:28], Index26, 2'b00} :
               (NPCSel == 2'b01 && BranchTaken) ? br_pc : seq_pc;
      ImAddr = PC_F[12:2];
      PC8_D  = PC_D + 32'd8;
   end
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         PC_F       <= PC_RESET;
         IR_D       <= '0;
         PC_D       <= '0;
         FetchErr_D <= 1'b0;
         FetchCnt   <= '0;
      end else if (!Stall) begin
         PC_F       <= npc;
         IR_D       <= legal ? ImData : 32'h0000_0000;
         PC_D       <= PC_F;
         FetchErr_D <= !legal;
         FetchCnt   <= FetchCnt + 32'd1;
      end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed checks of fetch, redirects, stall and reset.
module tb_ifu_fetch;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic [1:0]  npc_sel = 2'b00;
   logic        taken = 1'b0;
   logic [15:0] imm16 = '0;
   logic [25:0] index26 = '0;
   logic [31:0] reg_rs = '0;
   logic [10:0] im_addr;
   logic [31:0] im_data, pc_f, ir_d, pc_d, pc8_d, fetch_cnt;
   logic        fetch_err;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   // Memory word = 0xA0000000 | word address, so each fetched word identifies its slot.
   assign im_data = 32'hA000_0000 | {21'h0, im_addr};

   ifu_fetch dut (
      .Clk(clk), .Reset(rst), .Stall(stall), .NPCSel(npc_sel), .BranchTaken(taken),
      .Imm16(imm16), .Index26(index26), .RegRs(reg_rs), .ImAddr(im_addr),
      .ImData(im_data), .PC_F(pc_f), .IR_D(ir_d), .PC_D(pc_d), .PC8_D(pc8_d),
      .FetchErr_D(fetch_err), .FetchCnt(fetch_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_all(input string tag, input logic [31:0] e_pc_f, input logic [31:0] e_ir,
                          input logic [31:0] e_pc_d, input logic e_err, input logic [31:0] e_cnt);
      chk({tag, ".pc_f"}, pc_f, e_pc_f);
      chk({tag, ".ir_d"}, ir_d, e_ir);
      chk({tag, ".pc_d"}, pc_d, e_pc_d);
      chk({tag, ".pc8_d"}, pc8_d, e_pc_d + 32'd8);
      chk({tag, ".err"}, {31'h0, fetch_err}, {31'h0, e_err});
      chk({tag, ".cnt"}, fetch_cnt, e_cnt);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_all("reset", 32'h3000, 32'h0, 32'h0, 1'b0, 32'd0);
      chk("reset.imaddr", {21'h0, im_addr}, 32'h400);
      tick;
      chk_all("e1", 32'h3004, 32'hA000_0400, 32'h3000, 1'b0, 32'd1);
      tick;
      chk_all("e2", 32'h3008, 32'hA000_0401, 32'h3004, 1'b0, 32'd2);
      // taken branch back by one word from PC_D=0x3004: target 0x3004
      npc_sel = 2'b01; taken = 1'b1; imm16 = 16'hFFFF;
      tick;
      chk_all("br", 32'h3004, 32'hA000_0402, 32'h3008, 1'b0, 32'd3);
      npc_sel = 2'b01; taken = 1'b0;
      tick;
      chk_all("br_nt", 32'h3008, 32'hA000_0401, 32'h3004, 1'b0, 32'd4);
      npc_sel = 2'b00;
      tick;
      tick;
      tick;
      chk_all("e7", 32'h3014, 32'hA000_0404, 32'h3010, 1'b0, 32'd7);
      npc_sel = 2'b10; index26 = 26'h0000C40;
      tick;
      chk_all("jmp", 32'h3100, 32'hA000_0405, 32'h3014, 1'b0, 32'd8);
      stall = 1'b1; index26 = 26'h0000C80;
      tick;
      chk_all("stall1", 32'h3100, 32'hA000_0405, 32'h3014, 1'b0, 32'd8);
      tick;
      chk_all("stall2", 32'h3100, 32'hA000_0405, 32'h3014, 1'b0, 32'd8);
      stall = 1'b0;
      tick;
      chk_all("unstall", 32'h3200, 32'hA000_0440, 32'h3100, 1'b0, 32'd9);
      npc_sel = 2'b11; reg_rs = 32'h5000;
      tick;
      chk_all("jr", 32'h5000, 32'hA000_0480, 32'h3200, 1'b0, 32'd10);
      chk("jr.imaddr", {21'h0, im_addr}, 32'h400);
      reg_rs = 32'h3002;
      tick;
      chk_all("jr_oob", 32'h3002, 32'h0, 32'h5000, 1'b1, 32'd11);
      npc_sel = 2'b00;
      tick;
      chk_all("misalign", 32'h3006, 32'h0, 32'h3002, 1'b1, 32'd12);
      #2 rst = 1'b1;
      #1 chk_all("async_rst", 32'h3000, 32'h0, 32'h0, 1'b0, 32'd0);
      chk("async_rst.imaddr", {21'h0, im_addr}, 32'h400);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the pipelined MIPS core. It owns the program counter, drives the word address into the instruction memory, and latches the returned word into the IF/ID pipeline register. It also applies branch, jump and jr redirects resolved in the decode stage, using MIPS delay-slot semantics. It sits between the instruction memory and the decode stage.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_3000: PC value after reset.
- `PC_LO`, 32'h0000_3000: lowest legal fetch address.
- `PC_HI`, 32'h0000_4FFC: highest legal fetch address. This spans 2048 words.

Ports:
- `Clk`  in  1: single clock. All state changes on the rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `Stall`  in  1: holds the PC and the IF/ID register. Driven by the hazard unit.
- `NPCSel`  in  2: redirect select from decode. 00 = PC+4, 01 = branch, 10 = j/jal, 11 = jr.
- `BranchTaken`  in  1: comparison result for the branch in decode. Only meaningful when `NPCSel`=01.
- `Imm16`  in  16: branch offset of the instruction in decode.
- `Index26`  in  26: jump index of the instruction in decode.
- `RegRs`  in  32: forwarded rs value, used by jr.
- `ImAddr`  out  11: word address to instruction memory, equal to `PC[12:2]`.
- `ImData`  in  32: instruction word from memory. Combinational from `ImAddr` in the same cycle.
- `PC_F`  out  32: current fetch PC.
- `IR_D`  out  32: IF/ID instruction register.
- `PC_D`  out  32: IF/ID PC register.
- `PC8_D`  out  32: `PC_D`+8, the jal/jalr link value.
- `FetchErr_D`  out  1: the instruction in decode came from an illegal address.
- `FetchCnt`  out  32: count of instructions accepted into IF/ID.

## Operation
- Fetch legality: a fetch is legal when `PC_LO` ≤ `PC_F` ≤ `PC_HI` and `PC_F[1:0]`=00.
- Capture into IF/ID on each edge with `Stall`=0:
  - `IR_D` ← `ImData` if the fetch is legal, otherwise 32'h0000_0000 (nop).
  - `PC_D` ← `PC_F`.
  - `FetchErr_D` ← not legal.
  - `FetchCnt` ← `FetchCnt`+1. The counter wraps modulo 2^32.
- Next PC on each edge with `Stall`=0:
  - `NPCSel`=00: `PC_F`+4.
  - `NPCSel`=01 and `BranchTaken`=1: `PC_D`+4+(sign-extended `Imm16`<<2).
  - `NPCSel`=01 and `BranchTaken`=0: `PC_F`+4.
  - `NPCSel`=10: {`PC_D[31:28]`, `Index26`, 2'b00}.
  - `NPCSel`=11: `RegRs` unmodified. Misalignment is not masked; it is reported through `FetchErr_D` on the next capture.
- Delay slot: when a redirect is applied, the instruction already being fetched is the delay slot. It is captured normally and never flushed.
- Arithmetic: all adds are 32-bit and wrap silently. Wrap-around is caught only by the range check.
- `Stall`=1 takes priority over any redirect. PC, IF/ID and `FetchCnt` all hold. The redirect is re-evaluated on the first unstalled edge, because decode still holds the same instruction.
- `ImAddr` is always `PC_F[12:2]`, including for illegal PCs. Memory remapping of bit 12 is the memory's responsibility.

## Timing
- Reset values:
  - `PC_F`=`PC_RESET`.
  - `IR_D`=0.
  - `PC_D`=0.
  - `FetchErr_D`=0.
  - `FetchCnt`=0.
  - `PC8_D`=8, since it is combinational from `PC_D`.
- Reset takes effect immediately, without waiting for a clock edge. Assertion mid-stream discards the IF/ID contents and any pending redirect.
- Latency: an instruction at PC appears on `IR_D` one edge after `PC_F`=PC, with no wait states.
- Redirect: the branch target appears on `PC_F` after the same edge that captures the delay slot. The target instruction reaches `IR_D` one edge later.
- `PC_F`, `IR_D`, `PC_D`, `FetchErr_D` and `FetchCnt` are registered. `ImAddr` and `PC8_D` are combinational.

## Test plan
- Reset, then 3 free edges with memory words A,B,C at 0x3000/0x3004/0x3008:
  - after reset, `PC_F`=0x3000 and `ImAddr`=0x400;
  - `IR_D` shows A, then B, then C;
  - `PC_D` shows 0x3000, 0x3004, 0x3008;
  - `FetchCnt`=3.
- Taken branch with `PC_D`=0x3004, `Imm16`=0xFFFF:
  - next `PC_F`=0x3004;
  - the delay slot from 0x3008 is still captured.
- Jump with `PC_D`=0x3010, `Index26`=0x0000C40: next `PC_F`=0x3100.
- `Stall` held 2 edges together with `NPCSel`=10:
  - `PC_F`, `IR_D` and `FetchCnt` are unchanged during the stall;
  - the jump is applied on the first edge after `Stall` drops.
- jr with `RegRs`=0x5000:
  - next edge gives `PC_F`=0x5000;
  - the following edge gives `IR_D`=0 and `FetchErr_D`=1.
- jr with `RegRs`=0x3002: the captured `FetchErr_D`=1. Then assert `Reset` between edges: all outputs return to their reset values immediately.
